// File: rtl/regfile_bypass.sv
// Register file with one byte-enabled write port, two combinational read ports,
// optional same-cycle write forwarding, and a one-register-per-cycle clear sweep.
module regfile_bypass #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned BYPASS = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we3,
   input  logic [$clog2(DEPTH)-1:0]   wa3,
   input  logic [WIDTH-1:0]           wd3,
   input  logic [WIDTH/8-1:0]         be3,
   input  logic [$clog2(DEPTH)-1:0]   ra1,
   input  logic [$clog2(DEPTH)-1:0]   ra2,
   input  logic                       clr,
   output logic [WIDTH-1:0]           rd1,
   output logic [WIDTH-1:0]           rd2,
   output logic                       busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = WIDTH / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    idx_d;
   logic             busy_q;
   logic             sweep_c;
   logic             wr_acc_c;
   logic [WIDTH-1:0] wr_merged_c;
   logic [WIDTH-1:0] regs [DEPTH];

   // Writes are refused during a sweep and to the hard-wired zero register.
   assign wr_acc_c = we3 && !busy_q && (wa3 != '0);

   // New value of the target register after byte-lane merge.
   always_comb begin
      wr_merged_c = regs[wa3];
      for (int i = 0; i < int'(NB); i++) begin
         if (be3[i]) wr_merged_c[8*i +: 8] = wd3[8*i +: 8];
      end
   end

   always_comb begin
      rd1 = regs[ra1];
      if ((BYPASS != 0) && wr_acc_c && (ra1 == wa3)) rd1 = wr_merged_c;
      if (ra1 == '0) rd1 = '0;
   end

   always_comb begin
      rd2 = regs[ra2];
      if ((BYPASS != 0) && wr_acc_c && (ra2 == wa3)) rd2 = wr_merged_c;
      if (ra2 == '0) rd2 = '0;
   end

   // Clear FSM: state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= (state_d == CLEAR);
      end
   end

   // Clear FSM: next state. Sweep starts at 1 because register 0 is never written.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               idx_d   = AW'(1);
            end
         end
         CLEAR: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Clear FSM: outputs.
   always_comb begin
      sweep_c = 1'b0;
      if (state_q == CLEAR) sweep_c = 1'b1;
   end

   assign busy = busy_q;

   // Storage; a sweep and an accepted write are mutually exclusive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      end else begin
         if (wr_acc_c) regs[wa3] <= wr_merged_c;
         if (sweep_c) regs[idx_q] <= '0;
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: forwarding and non-forwarding instances share stimulus
// and are checked every cycle against a register-array model plus literal checks.
module tb_regfile_bypass;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we3 = 1'b0;
   logic [4:0]  wa3 = '0;
   logic [31:0] wd3 = '0;
   logic [3:0]  be3 = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic        clr = 1'b0;
   logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
   logic        busy_b1, busy_b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m [32];
   int          m_left = 0;

   regfile_bypass #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) u_dut_b1 (
      .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .be3(be3),
      .ra1(ra1), .ra2(ra2), .clr(clr), .rd1(rd1_b1), .rd2(rd2_b1), .busy(busy_b1)
   );

   regfile_bypass #(.WIDTH(32), .DEPTH(32), .BYPASS(0)) u_dut_b0 (
      .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .be3(be3),
      .ra1(ra1), .ra2(ra2), .clr(clr), .rd1(rd1_b0), .rd2(rd2_b0), .busy(busy_b0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic bit accept_now();
      return reset && we3 && (m_left == 0) && (wa3 != 5'd0);
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit fwd);
      if (ra == 5'd0) return 32'h0;
      if (fwd && accept_now() && (ra == wa3)) return merge(m[ra], wd3, be3);
      return m[ra];
   endfunction

   // Model: m_left counts sweep edges still to come; each sweep edge clears
   // the next register, starting from 1.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) m[i] = 32'h0;
         m_left = 0;
      end else begin
         if (accept_now()) m[wa3] = merge(m[wa3], wd3, be3);
         if (m_left > 0) begin
            m[32 - m_left] = 32'h0;
            m_left--;
         end else if (clr) begin
            m_left = 31;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy_b1", {31'b0, busy_b1}, {31'b0, m_left != 0});
      chk("busy_b0", {31'b0, busy_b0}, {31'b0, m_left != 0});
      chk("rd1_b1", rd1_b1, exp_rd(ra1, 1'b1));
      chk("rd2_b1", rd2_b1, exp_rd(ra2, 1'b1));
      chk("rd1_b0", rd1_b0, exp_rd(ra1, 1'b0));
      chk("rd2_b0", rd2_b0, exp_rd(ra2, 1'b0));
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
      we3 = 1'b1; wa3 = a; wd3 = d; be3 = b;
      cycle();
      we3 = 1'b0; be3 = 4'h0;
   endtask

   task automatic count_busy(input string name, input bit disturb);
      int cnt;
      cnt = 0;
      ra2 = 5'd31;
      while (busy_b1 && cnt < 40) begin
         cnt++;
         ra1 = 5'(cnt);
         we3 = 1'b0; clr = 1'b0;
         if (disturb && cnt == 3) begin
            we3 = 1'b1; wa3 = 5'd31; wd3 = 32'h7777_7777; be3 = 4'hF;
         end
         if (disturb && cnt == 5) clr = 1'b1;
         cycle();
      end
      we3 = 1'b0; clr = 1'b0;
      chk(name, 32'(cnt), 32'd31);
   endtask

   task automatic all_zero(input string name);
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #1;
         chk({name, "_b1"}, rd1_b1 | rd2_b1, 32'h0);
         chk({name, "_b0"}, rd1_b0 | rd2_b0, 32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) cycle();
      all_zero("reset_read");
      @(posedge clk); #1;
      reset = 1'b1;
      cycle();

      // Full write then read back; register 0 reads zero.
      wr(5'd5, 32'hDEAD_BEEF, 4'hF);
      ra1 = 5'd5; ra2 = 5'd0; #1;
      chk("r5_full", rd1_b1, 32'hDEAD_BEEF);
      chk("r0_read", rd2_b1, 32'h0);

      // Partial byte-lane write.
      wr(5'd5, 32'h1122_3344, 4'h5);
      #1;
      chk("r5_merge", rd1_b1, 32'hDE22_BE44);
      chk("r5_merge_b0", rd1_b0, 32'hDE22_BE44);

      // Same-cycle forwarding vs stored value.
      wr(5'd7, 32'h0102_0304, 4'hF);
      we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hA5A5_A5A5; be3 = 4'hF; ra1 = 5'd7; #1;
      chk("fwd_b1", rd1_b1, 32'hA5A5_A5A5);
      chk("nofwd_b0", rd1_b0, 32'h0102_0304);
      cycle();
      we3 = 1'b0; #1;
      chk("r7_after_b0", rd1_b0, 32'hA5A5_A5A5);

      // Write to r0 is discarded, even on the forwarding path.
      we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFF_FFFF; be3 = 4'hF; ra1 = 5'd0; #1;
      chk("r0_fwd", rd1_b1, 32'h0);
      cycle();
      we3 = 1'b0; #1;
      chk("r0_after", rd1_b1, 32'h0);

      // be3 = 0 leaves the target alone.
      we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h0; be3 = 4'h0; ra1 = 5'd5; #1;
      chk("be0_fwd", rd1_b1, 32'hDE22_BE44);
      cycle();
      we3 = 1'b0; #1;
      chk("be0_after", rd1_b1, 32'hDE22_BE44);

      // Fill, then clear with a same-edge write to r3.
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101, 4'hF);
      clr = 1'b1; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hCAFE_F00D; be3 = 4'hF;
      cycle();
      clr = 1'b0; we3 = 1'b0; ra1 = 5'd3; ra2 = 5'd31; #1;
      chk("clr_wr_r3", rd1_b1, 32'hCAFE_F00D);
      chk("unswept_r31", rd2_b1, 32'h1F1F_1F1F);
      chk("busy_start", {31'b0, busy_b1}, 32'd1);
      count_busy("clear_len", 1'b1);
      all_zero("after_clear");

      // Reset in the middle of a sweep.
      wr(5'd9, 32'h1234_5678, 4'hF);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (10) cycle();
      #2 reset = 1'b0;
      #1;
      chk("abort_busy_b1", {31'b0, busy_b1}, 32'd0);
      chk("abort_busy_b0", {31'b0, busy_b0}, 32'd0);
      all_zero("abort_read");
      @(posedge clk); #1;
      reset = 1'b1;
      cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      count_busy("clear_len2", 1'b0);
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
